// File: rtl/nios_system_switches_pkg.sv
// Shared definitions for the switch/key input port.
// Holds the Avalon register word addresses, the EDGE_TYPE encodings and the
// per-bit edge-detect rule so every file agrees on them.
package nios_system_switches_pkg;

  typedef enum logic [1:0] {
    REG_DATA     = 2'd0,
    REG_RESERVED = 2'd1,
    REG_IRQ_MASK = 2'd2,
    REG_EDGE_CAP = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // One-cycle edge term for every bit, given the current and previous
  // synchronized values. Any unknown encoding falls back to "any edge".
  function automatic logic [31:0] edge_detect(input int edge_type,
                                              input logic [31:0] cur,
                                              input logic [31:0] prev);
    case (edge_type)
      EDGE_RISING:  return cur & ~prev;
      EDGE_FALLING: return ~cur & prev;
      default:      return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/nios_system_switches_if.sv
// Avalon-MM slave bus bundle for the switch/key input port.
// Ports: address (word address), chipselect, write_n (active low),
// writedata, readdata (combinational read data from the slave).
interface nios_system_switches_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata);
endinterface

// File: rtl/nios_system_sync_cell.sv
// Single-bit multi-flop synchronizer for one asynchronous input.
// Ports: clk, reset (async active-high, clears every stage), d (async input),
// q (output of the last stage, STAGES clocks behind d).
module nios_system_sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/nios_system_switches.sv
// Parallel input port for switches/keys with edge capture and interrupt.
// Ports: clk, reset (async active-high), bus (Avalon-MM slave: address,
// chipselect, write_n, writedata, readdata), in_port (asynchronous inputs),
// irq (level interrupt = OR of unmasked captured edges).
// Registers: 0 data (RO), 1 reserved, 2 irq_mask (RW), 3 edge_capture (W1C).
module nios_system_switches
  import nios_system_switches_pkg::*;
#(
  parameter int WIDTH       = 18,
  parameter int EDGE_TYPE   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  nios_system_switches_if.slave  bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_term;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] clear_bits;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    nios_system_sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (in_port[i]),
      .q     (sync_q[i])
    );
  end

  // Upper writedata bits have no register behind them.
  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^bus.writedata[31:WIDTH];
  end

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign wr_bits = bus.writedata[WIDTH-1:0];

  // prev_q resets to zero alongside the synchronizer, so nothing is detected
  // right after reset; an input already high appears as a normal edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync_q;
    end
  end

  assign edge_term = WIDTH'(edge_detect(EDGE_TYPE, 32'(sync_q), 32'(prev_q)));

  always_comb begin
    clear_bits = '0;
    if (wr_en && (bus.address == REG_EDGE_CAP)) begin
      clear_bits = wr_bits;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_en && (bus.address == REG_IRQ_MASK)) begin
      irq_mask <= wr_bits;
    end
  end

  // The new edge is ORed in after the clear so a same-cycle edge survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clear_bits) | edge_term;
    end
  end

  // Built only from registers, so bus activity never reaches irq directly.
  assign irq = |(edge_capture & irq_mask);

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      REG_DATA:     bus.readdata = 32'(sync_q);
      REG_RESERVED: bus.readdata = '0;
      REG_IRQ_MASK: bus.readdata = 32'(irq_mask);
      REG_EDGE_CAP: bus.readdata = 32'(edge_capture);
      default:      bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_system_switches.sv
// Testbench for nios_system_switches: one any-edge and one rising-edge
// instance share clock, reset, in_port and identical bus traffic. A sample
// history model predicts readdata and irq, checked every falling clock edge,
// alongside directed literal checks and a randomized phase.
module tb_nios_system_switches;
  import nios_system_switches_pkg::*;

  localparam int          WIDTH = 18;
  localparam int          SYNC  = 2;
  localparam logic [31:0] WMASK = 32'h0003_FFFF;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_port = '0;
  logic             irq_any;
  logic             irq_rise;

  int checks = 0;
  int passes = 0;

  nios_system_switches_if bus_any ();
  nios_system_switches_if bus_rise ();

  nios_system_switches #(.WIDTH(WIDTH), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(SYNC)) dut_any (
    .clk(clk), .reset(reset), .bus(bus_any), .in_port(in_port), .irq(irq_any)
  );

  nios_system_switches #(.WIDTH(WIDTH), .EDGE_TYPE(EDGE_RISING), .SYNC_STAGES(SYNC)) dut_rise (
    .clk(clk), .reset(reset), .bus(bus_rise), .in_port(in_port), .irq(irq_rise)
  );

  always #5 clk = ~clk;

  // Model: hist[0] is the newest in_port sample; data visible after edge n is
  // the sample taken SYNC-1 edges earlier, the "previous" one is one older.
  logic [31:0] hist[$];
  logic [31:0] m_mask[2];
  logic [31:0] m_cap[2];

  always @(posedge clk or posedge reset) begin : model_blk
    logic [31:0] s, p, e;
    logic        wr;
    if (reset) begin
      hist = {};
      for (int i = 0; i <= SYNC; i++) hist.push_front(32'd0);
      for (int d = 0; d < 2; d++) begin
        m_mask[d] = 32'd0;
        m_cap[d]  = 32'd0;
      end
    end else begin
      s  = hist[SYNC-1];
      p  = hist[SYNC];
      wr = bus_any.chipselect && !bus_any.write_n;
      for (int d = 0; d < 2; d++) begin
        e = (d == 0) ? (s ^ p) : (s & ~p);
        if (wr && bus_any.address == 2'd3) m_cap[d] = m_cap[d] & ~(bus_any.writedata & WMASK);
        m_cap[d] = m_cap[d] | e;
        if (wr && bus_any.address == 2'd2) m_mask[d] = bus_any.writedata & WMASK;
      end
      hist.push_front(32'(in_port));
      void'(hist.pop_back());
    end
  end

  function automatic logic [31:0] m_read(input int d, input logic [1:0] a);
    case (a)
      2'd0:    return hist[SYNC-1];
      2'd1:    return 32'd0;
      2'd2:    return m_mask[d];
      default: return m_cap[d];
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (hist.size() > SYNC) begin
      check_output("model_rd_any",   bus_any.readdata,  m_read(0, bus_any.address));
      check_output("model_rd_rise",  bus_rise.readdata, m_read(1, bus_rise.address));
      check_output("model_irq_any",  {31'd0, irq_any},  {31'd0, |(m_cap[0] & m_mask[0])});
      check_output("model_irq_rise", {31'd0, irq_rise}, {31'd0, |(m_cap[1] & m_mask[1])});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    bus_any.address     = a;  bus_rise.address    = a;
    bus_any.chipselect  = cs; bus_rise.chipselect = cs;
    bus_any.write_n     = wn; bus_rise.write_n    = wn;
    bus_any.writedata   = wd; bus_rise.writedata  = wd;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    set_bus(a, 1'b1, 1'b0, wd);
    tick(1);
    set_bus(a, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic read_check(input string name, input int which, input logic [1:0] a, input logic [31:0] exp);
    bus_any.address  = a;
    bus_rise.address = a;
    #1;
    check_output(name, (which == 1) ? bus_rise.readdata : bus_any.readdata, exp);
  endtask

  task automatic apply_stimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0)
        set_bus(2'($urandom), 1'b1, 1'($urandom), $urandom);
      else
        set_bus(2'($urandom), 1'b0, 1'($urandom), $urandom);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
      end
      tick(1);
    end
    set_bus(2'd0, 1'b0, 1'b1, 32'd0);
  endtask

  initial begin
    set_bus(2'd0, 1'b0, 1'b1, 32'd0);
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state: all registers read zero, no interrupt.
    read_check("rst_data",  0, 2'd0, 32'd0);
    read_check("rst_resv",  0, 2'd1, 32'd0);
    read_check("rst_mask",  0, 2'd2, 32'd0);
    read_check("rst_cap",   0, 2'd3, 32'd0);
    check_output("rst_irq_any",  {31'd0, irq_any},  32'd0);
    check_output("rst_irq_rise", {31'd0, irq_rise}, 32'd0);

    // Latency of a 0->1 on bit 0 with mask bit 0 set.
    bus_write(2'd2, 32'h1);
    in_port[0] = 1'b1;
    tick(1);
    read_check("lat_data_early", 0, 2'd0, 32'd0);
    tick(1);
    read_check("lat_data",     0, 2'd0, 32'h1);
    read_check("lat_cap_early", 0, 2'd3, 32'd0);
    check_output("lat_irq_early", {31'd0, irq_any}, 32'd0);
    tick(1);
    read_check("lat_cap", 0, 2'd3, 32'h1);
    check_output("lat_irq", {31'd0, irq_any}, 32'd1);

    // Write-1-to-clear of one bit leaves the other.
    in_port[1] = 1'b1;
    tick(3);
    read_check("w1c_cap_before", 0, 2'd3, 32'h3);
    bus_write(2'd3, 32'h1);
    read_check("w1c_cap_after", 0, 2'd3, 32'h2);
    check_output("w1c_irq_drop", {31'd0, irq_any}, 32'd0);

    // Clear and new edge in the same cycle: the edge wins.
    in_port[0] = 1'b0;
    tick(3);
    read_check("race_cap_pre", 0, 2'd3, 32'h3);
    in_port[0] = 1'b1;
    tick(2);
    bus_write(2'd3, 32'h1);
    read_check("race_cap", 0, 2'd3, 32'h3);
    check_output("race_irq", {31'd0, irq_any}, 32'd1);

    // Rising-only instance ignores falling edges; mask enables irq later.
    in_port[5] = 1'b1;
    tick(4);
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, WMASK);
    in_port[5] = 1'b0;
    tick(4);
    read_check("rise_no_fall", 1, 2'd3, 32'h0);
    in_port[5] = 1'b1;
    tick(3);
    read_check("rise_cap", 1, 2'd3, 32'h20);
    check_output("rise_masked_irq", {31'd0, irq_rise}, 32'd0);
    bus_write(2'd2, 32'h20);
    check_output("rise_unmasked_irq", {31'd0, irq_rise}, 32'd1);
    read_check("rise_cap_kept", 1, 2'd3, 32'h20);

    // Reset mid-operation clears everything without a clock edge.
    reset = 1'b1;
    #1;
    check_output("async_irq", {31'd0, irq_rise}, 32'd0);
    read_check("async_mask", 1, 2'd2, 32'd0);
    read_check("async_cap",  1, 2'd3, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(1);

    apply_stimulus(3000);
    tick(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
